sharpen_seq: RTL and testbench
==============================

SHARPEN_SEQ -- requirements
Module: sharpen_seq

Interface
REQ-001 Parameter SRC_BASE, default 32'h000FF000: byte address of source image pixel (0,0).
REQ-002 Parameter DST_BASE, default 32'h000FF400: byte address of destination image pixel (0,0).
REQ-003 Parameters IMG_W and IMG_H, default 16 each, legal range 3..256: image width and height in pixels.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to process one full image.
REQ-008 busy  out  1  high while a run is in progress.
REQ-009 done  out  1  one-cycle pulse at the end of a run.
REQ-010 mem_req  out  1  memory transaction request.
REQ-011 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-012 mem_addr  out  32  word-aligned byte address; valid while mem_req=1.
REQ-013 mem_wdata  out  32  {24'b0, pixel}; valid while mem_we=1.
REQ-014 mem_ack  in  1  transaction completes in any cycle where mem_req=1 and mem_ack=1.
REQ-015 mem_rdata  in  32  read data, valid in the ack cycle; only bits [7:0] used.

Function
REQ-016 One pixel per 32-bit word; pixel (r,c) offset = (r*IMG_W + c)*4 from the base address.
REQ-017 FSM states: IDLE, RD, WR, GAP, FIN.
REQ-018 IDLE: start=1 -> RD for pixel (0,0); start SHALL be ignored in every other state.
REQ-019 Pixels SHALL be processed in raster order: row 0..IMG_H-1, column 0..IMG_W-1 within each row.
REQ-020 Border pixel (r=0, r=IMG_H-1, c=0 or c=IMG_W-1): 1 read of itself, then 1 write of the same value.
REQ-021 Interior pixel: 5 reads in order center, up (r-1), down (r+1), left (c-1), right (c+1), then 1 write.
REQ-022 Interior result = 5*center - up - down - left - right, computed in at least 12-bit signed; clamp <0 -> 0 and >255 -> 255.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and stay stable from assertion until the ack cycle.
REQ-024 After each ack, mem_req SHALL be low for exactly one GAP cycle; the next transaction is asserted in the cycle after GAP.
REQ-025 mem_ack SHALL be ignored while mem_req=0.
REQ-026 Read data SHALL be captured on the ack cycle edge only.
REQ-027 Wait states are unbounded: mem_req stays high until ack, with no timeout.
REQ-028 First mem_req SHALL be high in the cycle after the edge that samples start.
REQ-029 Final write ack -> FIN; FIN replaces GAP; done=1 for that one cycle; busy falls and state returns to IDLE at the end of FIN.
REQ-030 busy SHALL be 1 from the cycle after start is sampled through the FIN cycle, inclusive.
REQ-031 start asserted in the FIN cycle SHALL be ignored.
REQ-032 Row and column counters wrap: column IMG_W-1 advances to column 0 of the next row; row IMG_H-1 at column IMG_W-1 ends the run.
REQ-033 Source memory SHALL never be written, and destination memory never read.

Reset
REQ-034 On reset=1 at a clock edge: state=IDLE; busy, done, mem_req and mem_we = 0; mem_addr and mem_wdata = 0; counters = 0.
REQ-035 Reset asserted mid-transaction SHALL drop mem_req at that edge; the pending transaction is abandoned and a later start begins again at pixel (0,0).

Verification
REQ-036 IMG_W=IMG_H=4, zero-wait memory (ack tied high), start at edge E0 -> 32 reads, 16 writes, mem_req high in odd cycles 1..95 after E0, done=1 only in cycle 96, busy=1 in cycles 1..96.
REQ-037 Interior pixel with center 100 and up/down/left/right 90 -> written value 140 (32'h0000008C) to DST_BASE + offset.
REQ-038 Clamp cases -> center 0 with neighbors 255 writes 0; center 255 with neighbors 0 writes 255; border pixel 0xAB is copied as 0xAB.
REQ-039 Random ack delays of 0-5 cycles -> address, we and wdata stable while mem_req=1 without ack, exactly one GAP cycle after each ack, and memory image identical to the zero-wait run.
REQ-040 reset during the 10th read with mem_req high -> mem_req=0 and busy=0 the next cycle; a new start re-reads SRC_BASE first.
REQ-041 start pulsed while busy, and in the FIN cycle -> no restart, total transaction count unchanged.

Source files
------------

// File: rtl/sharpen_seq_if.sv
// Purpose: control handshake and single-port memory bus between the sharpen sequencer and its memory.
// Latency: pure wiring, no storage.
// Backpressure: memory stalls a transaction by holding mem_ack low while mem_req is high.
interface sharpen_seq_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // Sequencer side: drives the request, consumes ack/data.
    modport master (
        input  start, mem_ack, mem_rdata,
        output busy, done, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Memory/host side.
    modport slave (
        output start, mem_ack, mem_rdata,
        input  busy, done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sharpen_seq.sv
// Purpose: walks an image in raster order, writing a 5-point sharpened copy (borders copied) to a second buffer.
// Latency: 2 cycles per memory transaction at zero wait (request + one idle gap); done one cycle after the last write ack.
// Backpressure: every request is held stable until mem_ack; wait states are unbounded.
module sharpen_seq #(
    parameter logic [31:0] SRC_BASE = 32'h000FF000,
    parameter logic [31:0] DST_BASE = 32'h000FF400,
    parameter int          IMG_W    = 16,
    parameter int          IMG_H    = 16
) (
    input  logic          clk,
    input  logic          reset,
    sharpen_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, GAP, FIN} state_t;

    state_t      state, state_nxt;
    logic [8:0]  row, row_nxt;
    logic [8:0]  col, col_nxt;
    // Index of the next read for this pixel: 0 centre, 1 up, 2 down, 3 left, 4 right.
    logic [2:0]  step, step_nxt;
    // Signed running sum; 12 bits covers -1020..1275.
    logic [11:0] acc, acc_nxt;
    logic        req, req_nxt;
    logic        we, we_nxt;
    logic        busy_r, busy_nxt;
    logic        done_r, done_nxt;
    logic [31:0] addr, addr_nxt;
    logic [31:0] wdata, wdata_nxt;

    logic        border;
    logic        last_pix;
    logic        wr_due;
    logic [8:0]  nb_row, nb_col;
    logic [31:0] rd_addr, wr_addr;
    logic [11:0] pix_ext;
    logic [7:0]  clamped;
    logic        unused_rdata_hi;

    assign border   = (row == 9'd0) || (row == 9'(IMG_H - 1)) ||
                      (col == 9'd0) || (col == 9'(IMG_W - 1));
    assign last_pix = (row == 9'(IMG_H - 1)) && (col == 9'(IMG_W - 1));
    // Border pixels write after their single read; interior after all five.
    assign wr_due   = border ? (step == 3'd1) : (step == 3'd5);
    assign pix_ext  = {4'b0, bus.mem_rdata[7:0]};
    assign unused_rdata_hi = ^bus.mem_rdata[31:8];
    assign clamped  = acc[11]      ? 8'd0   :
                      (|acc[10:8]) ? 8'd255 : acc[7:0];

    // Neighbour coordinate selected by the read step.
    always_comb begin
        nb_row = row;
        nb_col = col;
        case (step)
            3'd1:    nb_row = row - 9'd1;
            3'd2:    nb_row = row + 9'd1;
            3'd3:    nb_col = col - 9'd1;
            3'd4:    nb_col = col + 9'd1;
            default: ;
        endcase
    end

    assign rd_addr = SRC_BASE + ((32'(nb_row) * 32'(IMG_W) + 32'(nb_col)) << 2);
    assign wr_addr = DST_BASE + ((32'(row) * 32'(IMG_W) + 32'(col)) << 2);

    // Next-state, counter and bus-register decode.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        step_nxt  = step;
        acc_nxt   = acc;
        req_nxt   = req;
        we_nxt    = we;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RD;
                    row_nxt   = 9'd0;
                    col_nxt   = 9'd0;
                    step_nxt  = 3'd0;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = SRC_BASE;
                end
            end
            RD: begin
                if (bus.mem_ack) begin
                    state_nxt = GAP;
                    req_nxt   = 1'b0;
                    step_nxt  = step + 3'd1;
                    if (step == 3'd0)
                        acc_nxt = border ? pix_ext : ((pix_ext << 2) + pix_ext);
                    else
                        acc_nxt = acc - pix_ext;
                end
            end
            GAP: begin
                req_nxt = 1'b1;
                if (wr_due) begin
                    state_nxt = WR;
                    we_nxt    = 1'b1;
                    addr_nxt  = wr_addr;
                    wdata_nxt = {24'b0, clamped};
                end else begin
                    state_nxt = RD;
                    we_nxt    = 1'b0;
                    addr_nxt  = rd_addr;
                end
            end
            WR: begin
                if (bus.mem_ack) begin
                    req_nxt  = 1'b0;
                    we_nxt   = 1'b0;
                    step_nxt = 3'd0;
                    if (last_pix) begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        if (col == 9'(IMG_W - 1)) begin
                            col_nxt = 9'd0;
                            row_nxt = row + 9'd1;
                        end else begin
                            col_nxt = col + 9'd1;
                        end
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Counters, accumulator and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            row    <= 9'd0;
            col    <= 9'd0;
            step   <= 3'd0;
            acc    <= 12'd0;
            req    <= 1'b0;
            we     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            addr   <= 32'd0;
            wdata  <= 32'd0;
        end else begin
            row    <= row_nxt;
            col    <= col_nxt;
            step   <= step_nxt;
            acc    <= acc_nxt;
            req    <= req_nxt;
            we     <= we_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            addr   <= addr_nxt;
            wdata  <= wdata_nxt;
        end
    end

    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_sharpen_seq.sv
// Purpose: directed bench for sharpen_seq on a 4x4 image with a behavioural memory.
// Latency: checks the exact cycle timing of a zero-wait run and the results of stalled runs.
// Backpressure: memory ack is tied high, randomly delayed 0-5 cycles, or held low.
module tb_sharpen_seq;
    localparam logic [31:0] SRC_BASE = 32'h000FF000;
    localparam logic [31:0] DST_BASE = 32'h000FF400;

    logic clk;
    logic reset;
    sharpen_seq_if bus();

    sharpen_seq #(.SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .IMG_W(4), .IMG_H(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  src_img [16];
    logic [31:0] dst_mem [16];
    logic [31:0] ref_dst [16];

    int ack_mode = 0;   // 0 tied high, 1 random 0-5 wait, 2 held low
    int clr_seq  = 0;
    int clr_seen = 0;
    int chk_timing = 0;
    int cyc = 100000;
    int timing_viol, stable_viol, gap_viol, stall_cnt;
    int rd_cnt, wr_cnt, bad_acc, done_cnt, done_cyc;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr_seq++;
    endtask

    task automatic load_img(input int which);
        logic [7:0] img_a [16];
        img_a = '{8'hAB, 8'd90, 8'd255, 8'd7,
                  8'd90, 8'd100, 8'd90, 8'd0,
                  8'd50, 8'd90, 8'd0, 8'd255,
                  8'd1, 8'd2, 8'd255, 8'd3};
        for (int i = 0; i < 16; i++) begin
            case (which)
                0:       src_img[i] = img_a[i];
                1:       src_img[i] = (i == 5) ? 8'd0 : 8'd255;
                default: src_img[i] = (i == 5) ? 8'd255 : 8'd0;
            endcase
        end
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int   n;
        logic seen;
        n    = 0;
        seen = bus.done;
        while (!seen && n < max_cyc) begin
            tick();
            n++;
            seen = bus.done;
        end
        chk_eq("done_seen", 32'(seen), 32'd1);
    endtask

    function automatic int px(input int r, input int c);
        return int'(src_img[r * 4 + c]);
    endfunction

    function automatic int model_pix(input int r, input int c);
        int v;
        if (r == 0 || r == 3 || c == 0 || c == 3) return px(r, c);
        v = 5 * px(r, c) - px(r - 1, c) - px(r + 1, c) - px(r, c - 1) - px(r, c + 1);
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic check_model(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < 16; i++)
            if (dst_mem[i] !== 32'(model_pix(i / 4, i % 4))) mism++;
        chk_eq(tag, 32'(mism), 32'd0);
    endtask

    // Memory model and bus monitor, all sampled on the falling edge.
    initial begin
        logic        ack_now, prev_req, prev_ack, prev_gap, cur_gap;
        logic        prev_we, w_req, w_done, w_busy;
        logic [31:0] prev_addr, prev_wdata, src_w, dst_w;
        int          wait_left;
        prev_req = 0; prev_ack = 0; prev_gap = 0; prev_we = 0;
        prev_addr = 0; prev_wdata = 0; wait_left = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (clr_seq != clr_seen) begin
                clr_seen = clr_seq;
                timing_viol = 0; stable_viol = 0; gap_viol = 0; stall_cnt = 0;
                rd_cnt = 0; wr_cnt = 0; bad_acc = 0; done_cnt = 0; done_cyc = 0;
                prev_req = 0; prev_ack = 0; prev_gap = 0;
                for (int i = 0; i < 16; i++) dst_mem[i] = 32'hDEADBEEF;
            end
            if (ack_mode == 0)      ack_now = 1'b1;
            else if (ack_mode == 2) ack_now = 1'b0;
            else if (bus.mem_req) begin
                if (wait_left == 0) ack_now = 1'b1;
                else begin ack_now = 1'b0; wait_left--; end
            end else begin
                ack_now   = 1'b0;
                wait_left = $urandom_range(0, 5);
            end
            bus.mem_ack = ack_now;
            src_w = (bus.mem_addr - SRC_BASE) >> 2;
            dst_w = (bus.mem_addr - DST_BASE) >> 2;
            bus.mem_rdata = (src_w < 16) ? {24'hA5A5A5, src_img[src_w[3:0]]} : 32'hBAD0BAD0;

            if (bus.start && !bus.busy) cyc = 0;
            else if (cyc < 100000)      cyc++;
            if (chk_timing != 0 && cyc >= 1 && cyc <= 110) begin
                w_req  = (cyc % 2 == 1) && (cyc <= 95);
                w_done = (cyc == 96);
                w_busy = (cyc <= 96);
                if (bus.mem_req !== w_req || bus.done !== w_done || bus.busy !== w_busy)
                    timing_viol++;
            end
            if (prev_req && !prev_ack) begin
                stall_cnt++;
                if (!bus.mem_req || bus.mem_addr !== prev_addr || bus.mem_we !== prev_we ||
                    (prev_we && bus.mem_wdata !== prev_wdata))
                    stable_viol++;
            end
            if (prev_req && prev_ack && bus.mem_req) gap_viol++;
            if (prev_gap && !bus.mem_req) gap_viol++;
            cur_gap = !bus.mem_req && prev_req && prev_ack && !bus.done;

            if (bus.mem_req && ack_now) begin
                if (bus.mem_we) begin
                    if (dst_w < 16) begin
                        dst_mem[dst_w[3:0]] = bus.mem_wdata;
                        wr_cnt++;
                    end else bad_acc++;
                end else begin
                    if (src_w < 16) rd_cnt++;
                    else            bad_acc++;
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_req = bus.mem_req; prev_ack = ack_now; prev_gap = cur_gap;
            prev_we = bus.mem_we; prev_addr = bus.mem_addr; prev_wdata = bus.mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, guard, diff;
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (3) tick();
        chk_eq("rst_busy",  32'(bus.busy),    32'd0);
        chk_eq("rst_done",  32'(bus.done),    32'd0);
        chk_eq("rst_req",   32'(bus.mem_req), 32'd0);
        chk_eq("rst_we",    32'(bus.mem_we),  32'd0);
        chk_eq("rst_addr",  bus.mem_addr,     32'd0);
        chk_eq("rst_wdata", bus.mem_wdata,    32'd0);
        reset = 1'b0;
        tick();

        // Zero-wait run on image A: exact cycle pattern and hand-computed pixels.
        load_img(0); clear_stats(); ack_mode = 0; chk_timing = 1;
        start_run();
        wait_done(400);
        repeat (15) tick();
        chk_timing = 0;
        chk_eq("zw_timing_viol", 32'(timing_viol), 32'd0);
        chk_eq("zw_reads",       32'(rd_cnt),      32'd32);
        chk_eq("zw_writes",      32'(wr_cnt),      32'd16);
        chk_eq("zw_done_cnt",    32'(done_cnt),    32'd1);
        chk_eq("zw_done_cyc",    32'(done_cyc),    32'd96);
        chk_eq("zw_bad_access",  32'(bad_acc),     32'd0);
        chk_eq("zw_gap_viol",    32'(gap_viol),    32'd0);
        chk_eq("a_pix_1_1",      dst_mem[5],       32'h0000008C);
        chk_eq("a_border_0_0",   dst_mem[0],       32'h000000AB);
        chk_eq("a_pix_1_2",      dst_mem[6],       32'd95);
        chk_eq("a_pix_2_1_hi",   dst_mem[9],       32'd255);
        chk_eq("a_pix_2_2_lo",   dst_mem[10],      32'd0);
        chk_eq("a_border_3_2",   dst_mem[14],      32'd255);
        check_model("a_model");
        for (int i = 0; i < 16; i++) ref_dst[i] = dst_mem[i];

        // Random wait states: bus stability, single gap, same image.
        load_img(0); clear_stats(); ack_mode = 1;
        start_run();
        wait_done(3000);
        repeat (3) tick();
        diff = 0;
        for (int i = 0; i < 16; i++) if (dst_mem[i] !== ref_dst[i]) diff++;
        chk_eq("rw_stable_viol", 32'(stable_viol),    32'd0);
        chk_eq("rw_gap_viol",    32'(gap_viol),       32'd0);
        chk_eq("rw_stalls_seen", 32'(stall_cnt > 0),  32'd1);
        chk_eq("rw_reads",       32'(rd_cnt),         32'd32);
        chk_eq("rw_writes",      32'(wr_cnt),         32'd16);
        chk_eq("rw_bad_access",  32'(bad_acc),        32'd0);
        chk_eq("rw_image_diff",  32'(diff),           32'd0);

        // Clamp cases.
        load_img(1); clear_stats(); ack_mode = 0;
        start_run();
        wait_done(400);
        repeat (3) tick();
        chk_eq("b_clamp_low",    dst_mem[5], 32'd0);
        chk_eq("b_pix_1_2_high", dst_mem[6], 32'd255);
        check_model("b_model");

        load_img(2); clear_stats();
        start_run();
        wait_done(400);
        repeat (3) tick();
        chk_eq("c_clamp_high", dst_mem[5], 32'd255);
        chk_eq("c_pix_1_2",    dst_mem[6], 32'd0);
        check_model("c_model");

        // Reset during the 10th read, then a clean restart.
        load_img(0); clear_stats(); ack_mode = 0;
        start_run();
        n = 1; guard = 0;
        while (n < 10 && guard < 200) begin
            tick();
            guard++;
            if (bus.mem_req && !bus.mem_we) n++;
        end
        chk_eq("rst10_reached", 32'(n), 32'd10);
        ack_mode = 2;
        reset    = 1'b1;
        tick();
        chk_eq("rst10_req",  32'(bus.mem_req), 32'd0);
        chk_eq("rst10_busy", 32'(bus.busy),    32'd0);
        reset = 1'b0; ack_mode = 0;
        tick();
        clear_stats();
        start_run();
        chk_eq("restart_addr", bus.mem_addr,     SRC_BASE);
        chk_eq("restart_rd",   32'(bus.mem_req && !bus.mem_we), 32'd1);
        wait_done(400);
        repeat (3) tick();
        chk_eq("restart_reads",  32'(rd_cnt), 32'd32);
        chk_eq("restart_writes", 32'(wr_cnt), 32'd16);
        check_model("restart_model");

        // start while busy and in the FIN cycle must not restart.
        load_img(0); clear_stats();
        start_run();
        repeat (30) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(400);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk_eq("fin_start_busy",   32'(bus.busy), 32'd0);
        chk_eq("fin_start_reads",  32'(rd_cnt),   32'd32);
        chk_eq("fin_start_writes", 32'(wr_cnt),   32'd16);
        chk_eq("fin_start_dones",  32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
